// File: rtl/pattern_detect_controller.sv
// Programmable serial pattern detector with a config/start/done run controller.
// Latency: detected/done/cfg_err registered one cycle after the sampling edge; cfg_ready, busy combinational from state.
// Backpressure: cfg_ready low while a run is active; a_valid low stalls the detector. Optional abort: PATTERN_DETECT_CTRL_ABORT_EN.
module pattern_detect_controller #(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic [CNT_W-1:0]   cfg_target,
   output logic               cfg_err,
   input  logic               start,
`ifdef PATTERN_DETECT_CTRL_ABORT_EN
   input  logic               abort,
`endif
   input  logic               a_valid,
   input  logic               a,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_len;
   logic [CNT_W-1:0]   r_target;
   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic [CNT_W-1:0]   r_count;
   logic               r_detected;
   logic               r_done;
   logic               r_cfg_err;

   logic               w_abort;
   logic               w_cfg_hs;
   logic               w_len_ok;
   logic               w_go;
   logic               w_shift;
   logic [MAX_LEN-1:0] w_hist_new;
   logic [MAX_LEN-1:0] w_mask;
   logic [LEN_W-1:0]   w_fill_inc;
   logic [LEN_W:0]     w_fill_p1;
   logic               w_match;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_hit;

`ifdef PATTERN_DETECT_CTRL_ABORT_EN
   assign w_abort = abort && (r_state == S_RUN);
`else
   assign w_abort = 1'b0;
`endif

   // Handshake, match evaluation on the post-shift history, and saturating count.
   always_comb begin
      w_cfg_hs   = cfg_valid && (r_state != S_RUN);
      w_len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
      w_go       = (r_state == S_ARMED) && start && !w_cfg_hs;
      w_shift    = (r_state == S_RUN) && a_valid && !w_abort;
      w_hist_new = {r_hist[MAX_LEN-2:0], a};
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (LEN_W'(i) < r_len);
      end
      w_fill_inc = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
      w_fill_p1  = {1'b0, r_fill} + (LEN_W+1)'(1);
      w_match    = w_shift && (w_fill_p1 >= {1'b0, r_len}) &&
                   ((w_hist_new & w_mask) == (r_pattern & w_mask));
      w_cnt_inc  = (&r_count) ? r_count : r_count + CNT_W'(1);
      w_hit      = w_match && (r_target != '0) && (w_cnt_inc == r_target);
   end

   // Next-state and combinational status outputs.
   always_comb begin
      w_state_nxt = r_state;
      cfg_ready   = (r_state != S_RUN);
      busy        = (r_state == S_RUN);
      case (r_state)
         S_IDLE:  if (w_cfg_hs && w_len_ok) w_state_nxt = S_ARMED;
         S_ARMED: if (w_go) w_state_nxt = S_RUN;
         S_RUN:   if (w_abort || w_hit) w_state_nxt = S_ARMED;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Config storage, history/fill shift register, match counter and output pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pattern  <= '0;
         r_len      <= '0;
         r_target   <= '0;
         r_hist     <= '0;
         r_fill     <= '0;
         r_count    <= '0;
         r_detected <= 1'b0;
         r_done     <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_detected <= w_match;
         r_done     <= w_hit;
         r_cfg_err  <= w_cfg_hs && !w_len_ok;
         if (w_cfg_hs && w_len_ok) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_target  <= cfg_target;
         end
         if (w_go) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
         end else if (w_shift) begin
            r_hist <= w_hist_new;
            r_fill <= w_fill_inc;
            if (w_match) r_count <= w_cnt_inc;
         end
      end
   end

   assign detected    = r_detected;
   assign done        = r_done;
   assign cfg_err     = r_cfg_err;
   assign match_count = r_count;

endmodule

// File: tb/tb_pattern_detect_controller.sv
module tb_pattern_detect_controller;
   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               cfg_valid = 1'b0;
   logic               cfg_ready;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic [CNT_W-1:0]   cfg_target = '0;
   logic               cfg_err;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic               a_valid = 1'b0;
   logic               a = 1'b0;
   logic               detected;
   logic [CNT_W-1:0]   match_count;
   logic               busy;
   logic               done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: stream of bits seen in the current run, compared by tail.
   int m_pat, m_len, m_target, m_cnt;
   bit m_running, m_det, m_done;
   bit m_q[$];

   pattern_detect_controller #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_err(cfg_err),
      .start(start),
`ifdef PATTERN_DETECT_CTRL_ABORT_EN
      .abort(abort),
`endif
      .a_valid(a_valid), .a(a),
      .detected(detected), .match_count(match_count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void m_reset();
      m_running = 0; m_cnt = 0; m_det = 0; m_done = 0; m_q.delete();
   endfunction

   function automatic void m_bit(bit vld, bit v);
      bit hit;
      m_det = 0; m_done = 0;
      if (!m_running || !vld) return;
      m_q.push_back(v);
      if (m_q.size() < m_len) return;
      hit = 1;
      for (int k = 0; k < m_len; k++)
         if (m_q[m_q.size()-1-k] != m_pat[k]) hit = 0;
      if (!hit) return;
      m_det = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_target != 0 && m_cnt == m_target) begin
         m_done = 1;
         m_running = 0;
      end
   endfunction

   task automatic apply_reset();
      rst = 0; cfg_valid = 0; start = 0; a_valid = 0; abort = 0;
      step();
      rst = 1;
      m_reset();
   endtask

   task automatic do_cfg(input int pat, input int len, input int target);
      cfg_valid = 1; cfg_pattern = MAX_LEN'(pat); cfg_len = LEN_W'(len); cfg_target = CNT_W'(target);
      step();
      cfg_valid = 0;
      if (len >= 1 && len <= MAX_LEN) begin
         m_pat = pat; m_len = len; m_target = target;
      end
   endtask

   task automatic do_start();
      start = 1;
      step();
      start = 0;
      m_q.delete(); m_cnt = 0; m_running = 1;
   endtask

   task automatic test_reset();
      rst = 0;
      #2;
      step();
      rst = 1;
      m_reset();
      n_checks++;
      if (cfg_ready !== 1'b1 || busy !== 1'b0 || detected !== 1'b0 || done !== 1'b0 ||
          match_count !== '0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got rdy=%b busy=%b det=%b done=%b cnt=%0d err=%b, want 1 0 0 0 0 0",
                  cfg_ready, busy, detected, done, match_count, cfg_err);
      end
      start = 1;
      step();
      start = 0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_overlap();
      bit bits[6] = '{1, 0, 1, 0, 1, 0};
      bit exp_det[6] = '{0, 0, 0, 1, 0, 1};
      do_cfg(4'b1010, 4, 2);
      do_start();
      n_checks++;
      if (busy !== 1'b1 || match_count !== '0) begin
         n_fail++;
         $display("FAIL overlap_start: busy=%b cnt=%0d want 1 0", busy, match_count);
      end
      foreach (bits[i]) begin
         a_valid = 1; a = bits[i];
         step();
         m_bit(1, bits[i]);
         n_checks++;
         if (detected !== exp_det[i] || detected !== m_det || done !== m_done ||
             match_count !== CNT_W'(m_cnt) || busy !== m_running) begin
            n_fail++;
            $display("FAIL overlap_bit%0d: det=%b done=%b cnt=%0d busy=%b want %b %b %0d %b",
                     i+1, detected, done, match_count, busy, exp_det[i], m_done, m_cnt, m_running);
         end
      end
      a_valid = 0;
      step();
      n_checks++;
      if (match_count !== 8'd2 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL overlap_end: cnt=%0d busy=%b done=%b want 2 0 0", match_count, busy, done);
      end
      do_start();
      n_checks++;
      if (busy !== 1'b1 || match_count !== '0) begin
         n_fail++;
         $display("FAIL overlap_rerun: busy=%b cnt=%0d want 1 0", busy, match_count);
      end
      apply_reset();
   endtask

   task automatic test_continuous();
      logic [23:0] stream = 24'b0011_0101_1001_1001_1010_1000;
      do_cfg(6'b100110, 6, 0);
      do_start();
      for (int i = 0; i < 24; i++) begin
         a_valid = 1; a = stream[23-i];
         step();
         m_bit(1, stream[23-i]);
         n_checks++;
         if (detected !== ((i+1 == 14) || (i+1 == 18)) || detected !== m_det ||
             done !== 1'b0 || match_count !== CNT_W'(m_cnt) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL continuous_bit%0d: det=%b done=%b cnt=%0d busy=%b want det=%b done=0 cnt=%0d busy=1",
                     i+1, detected, done, match_count, busy, m_det, m_cnt);
         end
      end
      a_valid = 0;
      n_checks++;
      if (match_count !== 8'd2) begin
         n_fail++;
         $display("FAIL continuous_count: cnt=%0d want 2", match_count);
      end
   endtask

   // Entered while the continuous run is still active.
   task automatic test_cfg_errors();
      cfg_valid = 1; cfg_pattern = 8'hFF; cfg_len = 4'd3; cfg_target = 8'd1;
      #1;
      n_checks++;
      if (cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_in_run_ready: rdy=%b want 0", cfg_ready);
      end
      step();
      cfg_valid = 0;
      n_checks++;
      if (busy !== 1'b1 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_in_run: busy=%b err=%b want 1 0", busy, cfg_err);
      end
      // Asynchronous reset between edges.
      rst = 0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || detected !== 1'b0 || done !== 1'b0 || match_count !== '0 || cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_midrun: busy=%b det=%b done=%b cnt=%0d rdy=%b want 0 0 0 0 1",
                  busy, detected, done, match_count, cfg_ready);
      end
      step();
      rst = 1;
      m_reset();
      do_cfg(0, MAX_LEN + 1, 0);
      n_checks++;
      if (cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_len_over: err=%b want 1", cfg_err);
      end
      step();
      n_checks++;
      if (cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_err_width: err=%b want 0", cfg_err);
      end
      do_start();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_err_idle_kept: busy=%b want 0", busy);
      end
      // Config together with start: config wins.
      cfg_valid = 1; cfg_pattern = 8'b11; cfg_len = 4'd2; cfg_target = 8'd1; start = 1;
      step();
      cfg_valid = 0; start = 0;
      m_pat = 3; m_len = 2; m_target = 1;
      n_checks++;
      if (busy !== 1'b0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_start_same: busy=%b err=%b want 0 0", busy, cfg_err);
      end
      do_cfg(0, 0, 0);
      n_checks++;
      if (cfg_err !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_len_zero: err=%b want 1", cfg_err);
      end
      do_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_err_armed_kept: busy=%b want 1", busy);
      end
      apply_reset();
   endtask

   task automatic test_gaps();
      bit bits[6] = '{1, 0, 1, 0, 1, 0};
      int idx = 0;
      int guard = 0;
      do_cfg(4'b1010, 4, 2);
      do_start();
      while (idx < 6 && guard < 100) begin
         bit v;
         guard++;
         v = ($urandom_range(0, 2) != 0);
         a_valid = v; a = v ? bits[idx] : bit'($urandom_range(0, 1));
         step();
         m_bit(v, bits[idx]);
         if (v) idx++;
         n_checks++;
         if (detected !== m_det || (!v && detected !== 1'b0) || done !== m_done ||
             match_count !== CNT_W'(m_cnt) || busy !== m_running) begin
            n_fail++;
            $display("FAIL gaps_cycle%0d: vld=%b det=%b done=%b cnt=%0d busy=%b want %b %b %0d %b",
                     guard, v, detected, done, match_count, busy, m_det, m_done, m_cnt, m_running);
         end
      end
      a_valid = 0;
      n_checks++;
      if (idx != 6 || match_count !== 8'd2) begin
         n_fail++;
         $display("FAIL gaps_end: bits=%0d cnt=%0d want 6 2", idx, match_count);
      end
      apply_reset();
   endtask

   task automatic test_random();
      for (int run = 0; run < 12; run++) begin
         int len = $urandom_range(1, 4);
         do_cfg($urandom_range(0, 255), len, $urandom_range(0, 3));
         do_start();
         for (int c = 0; c < 40; c++) begin
            bit v = ($urandom_range(0, 3) != 0);
            bit d = bit'($urandom_range(0, 1));
            a_valid = v; a = d;
            step();
            m_bit(v, d);
            n_checks++;
            if (detected !== m_det || done !== m_done || match_count !== CNT_W'(m_cnt) || busy !== m_running) begin
               n_fail++;
               $display("FAIL random_r%0d_c%0d: det=%b done=%b cnt=%0d busy=%b want %b %b %0d %b",
                        run, c, detected, done, match_count, busy, m_det, m_done, m_cnt, m_running);
            end
         end
         apply_reset();
      end
   endtask

   task automatic test_saturate();
      do_cfg(1, 1, 0);
      do_start();
      for (int c = 0; c < CNT_MAX + 5; c++) begin
         a_valid = 1; a = 1;
         step();
         m_bit(1, 1);
         n_checks++;
         if (match_count !== CNT_W'(m_cnt) || detected !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_c%0d: cnt=%0d det=%b want %0d 1", c, match_count, detected, m_cnt);
         end
      end
      apply_reset();
   endtask

`ifdef PATTERN_DETECT_CTRL_ABORT_EN
   task automatic test_abort();
      bit bits[3] = '{1, 0, 1};
      do_cfg(4'b1010, 4, 0);
      do_start();
      foreach (bits[i]) begin
         a_valid = 1; a = bits[i];
         step();
      end
      a = 0; abort = 1;
      step();
      abort = 0; a_valid = 0;
      n_checks++;
      if (detected !== 1'b0 || done !== 1'b0 || match_count !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_on_match: det=%b done=%b cnt=%0d busy=%b want 0 0 0 0",
                  detected, done, match_count, busy);
      end
      do_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_rerun: busy=%b want 1", busy);
      end
      apply_reset();
   endtask
`endif

   initial begin
      m_reset();
      m_pat = 0; m_len = 1; m_target = 0;
      test_reset();
      test_overlap();
      test_continuous();
      test_cfg_errors();
      test_gaps();
      test_random();
      test_saturate();
`ifdef PATTERN_DETECT_CTRL_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, want finish before 2000000");
      $fatal(1, "timeout");
   end
endmodule
